// File: rtl/multi_channel_counter.sv
// multi_channel_counter: N independent up/down counters with per-channel
// limit, wrap/saturate mode and terminal-count pulse, plus a free-running
// cycle counter. Each channel is one mcc_lane instance.

// One counter channel: clear > load > enable, registered count and tc.
module mcc_lane #(
   parameter int WIDTH      = 8,
   parameter int INIT_VALUE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cke,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             down,
   input  logic             sat,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_bound
);
   localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VALUE);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   typedef struct packed {
      logic [WIDTH-1:0] count;
      logic             tc;
   } lane_st_t;

   lane_st_t nxt;
   logic     tc_q;

   // next count/tc from the highest-priority request this cycle
   always_comb begin
      nxt.count = count;
      nxt.tc    = 1'b0;
      if (clear) begin
         nxt.count = INIT;
      end else if (load) begin
         nxt.count = load_value;
      end else if (enable) begin
         if (!down) begin
            if (!sat) begin
               if (count >= limit) begin
                  nxt.count = '0;
                  nxt.tc    = 1'b1;
               end else begin
                  nxt.count = count + ONE;
               end
            end else if (count >= limit) begin
               // at or above the bound: clamp; tc only when actually clamping
               nxt.count = limit;
               nxt.tc    = (count > limit);
            end else begin
               nxt.count = count + ONE;
               nxt.tc    = (count == limit - ONE);
            end
         end else begin
            if (count == '0) begin
               // saturating down holds at 0 silently
               if (!sat) begin
                  nxt.count = limit;
                  nxt.tc    = 1'b1;
               end
            end else begin
               nxt.count = count - ONE;
               nxt.tc    = sat && (count == ONE);
            end
         end
      end
   end

   // state register; tc is dropped while cke is low so a stale pulse never reappears
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= INIT;
         tc_q  <= 1'b0;
      end else if (cke) begin
         count <= nxt.count;
         tc_q  <= nxt.tc;
      end else begin
         tc_q  <= 1'b0;
      end
   end

   // tc is forced low whenever the clock enable is off
   always_comb begin
      tc       = tc_q & cke;
      at_bound = down ? (count == '0) : (count == limit);
   end
endmodule

// Top: cycle counter plus N channel lanes.
module multi_channel_counter #(
   parameter int N           = 4,
   parameter int WIDTH       = 8,
   parameter int CYCLE_WIDTH = 32,
   parameter int INIT_VALUE  = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cke,
   input  logic [N-1:0]           clear,
   input  logic [N-1:0]           load,
   input  logic [N*WIDTH-1:0]     load_value,
   input  logic [N-1:0]           enable,
   input  logic [N-1:0]           down,
   input  logic [N-1:0]           sat,
   input  logic [N*WIDTH-1:0]     limit,
   output logic [N*WIDTH-1:0]     count,
   output logic [N-1:0]           tc,
   output logic [N-1:0]           at_bound,
   output logic [CYCLE_WIDTH-1:0] cycle
);
   // free-running cycle count, wraps silently
   always_ff @(posedge clk) begin
      if (reset)    cycle <= '0;
      else if (cke) cycle <= cycle + CYCLE_WIDTH'(1);
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      mcc_lane #(
         .WIDTH      (WIDTH),
         .INIT_VALUE (INIT_VALUE)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .cke        (cke),
         .clear      (clear[i]),
         .load       (load[i]),
         .load_value (load_value[i*WIDTH +: WIDTH]),
         .enable     (enable[i]),
         .down       (down[i]),
         .sat        (sat[i]),
         .limit      (limit[i*WIDTH +: WIDTH]),
         .count      (count[i*WIDTH +: WIDTH]),
         .tc         (tc[i]),
         .at_bound   (at_bound[i])
      );
   end
endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed bench for multi_channel_counter (N=4, WIDTH=8, INIT_VALUE=0).
module tb_multi_channel_counter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            reset, cke;
   logic [N-1:0]    clear, load, enable, down, sat;
   logic [N*W-1:0]  load_value, limit;
   logic [N*W-1:0]  count;
   logic [N-1:0]    tc, at_bound;
   logic [CW-1:0]   cycle;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_cyc = 0;

   logic [7:0] e2_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
   logic       e2_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [7:0] e3_cnt [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
   logic       e3_tc  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic       e3_ab  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [7:0] e4_cnt [4] = '{8'd0, 8'd4, 8'd3, 8'd2};
   logic       e4_tc  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

   multi_channel_counter #(.N(N), .WIDTH(W), .CYCLE_WIDTH(CW), .INIT_VALUE(0)) dut (
      .clk(clk), .reset(reset), .cke(cke), .clear(clear), .load(load),
      .load_value(load_value), .enable(enable), .down(down), .sat(sat),
      .limit(limit), .count(count), .tc(tc), .at_bound(at_bound), .cycle(cycle)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] cnt(int i);
      return count[i*W +: W];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock; cycle reference advances on the same rule the block uses
   task automatic tick();
      @(posedge clk);
      if (reset)    exp_cyc = 0;
      else if (cke) exp_cyc = exp_cyc + 1;
      #1;
   endtask

   task automatic set_lim(int ch, logic [7:0] v);
      limit[ch*W +: W] = v;
   endtask

   task automatic set_lv(int ch, logic [7:0] v);
      load_value[ch*W +: W] = v;
   endtask

   initial begin
      reset = 1'b1; cke = 1'b1;
      clear = '0; load = '0; enable = '0; down = '0; sat = '0;
      load_value = '0; limit = '0;
      tick(); tick();
      chk("rst_count", count, 0);
      chk("rst_tc", tc, 0);
      chk("rst_cycle", cycle, 0);

      // reset while counting: ch0 at 37, cycle at 100
      reset = 1'b0;
      set_lim(0, 8'd255); set_lv(0, 8'd37); load[0] = 1'b1;
      tick();
      load[0] = 1'b0;
      repeat (99) tick();
      chk("pre_rst_cnt0", cnt(0), 37);
      chk("pre_rst_cycle", cycle, 100);
      reset = 1'b1; enable[0] = 1'b1;
      tick();
      chk("mid_rst_cnt0", cnt(0), 0);
      chk("mid_rst_tc", tc, 0);
      chk("mid_rst_cycle", cycle, 0);
      reset = 1'b0; enable[0] = 1'b0;
      tick();
      chk("post_rst_cycle1", cycle, 1);
      tick();
      chk("post_rst_cycle2", cycle, 2);

      // ch0 up/wrap, limit 5
      set_lim(0, 8'd5); enable[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("wrap_cnt0_%0d", k), cnt(0), e2_cnt[k]);
         chk($sformatf("wrap_tc0_%0d", k), tc[0], e2_tc[k]);
      end
      chk("wrap_cnt1_idle", cnt(1), 0);
      enable[0] = 1'b0;

      // ch1 up/sat, limit 3
      set_lim(1, 8'd3); sat[1] = 1'b1; enable[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("sat_cnt1_%0d", k), cnt(1), e3_cnt[k]);
         chk($sformatf("sat_tc1_%0d", k), tc[1], e3_tc[k]);
         chk($sformatf("sat_ab1_%0d", k), at_bound[1], e3_ab[k]);
      end
      enable[1] = 1'b0;

      // ch2 down/wrap, limit 4, start at 1
      down[2] = 1'b1; set_lim(2, 8'd4); set_lv(2, 8'd1); load[2] = 1'b1;
      tick();
      chk("dn_load_cnt2", cnt(2), 1);
      load[2] = 1'b0; enable[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("dn_cnt2_%0d", k), cnt(2), e4_cnt[k]);
         chk($sformatf("dn_tc2_%0d", k), tc[2], e4_tc[k]);
      end
      enable[2] = 1'b0; set_lv(2, 8'd9); load[2] = 1'b1;
      tick();
      chk("dn_load9_cnt2", cnt(2), 9);
      chk("dn_load9_ab2", at_bound[2], 0);
      load[2] = 1'b0; sat[2] = 1'b1; enable[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("dnsat_cnt2_%0d", k), cnt(2), 8 - k);
         chk($sformatf("dnsat_tc2_%0d", k), tc[2], 0);
      end
      enable[2] = 1'b0;

      // ch3 priority: clear > load > enable
      set_lim(3, 8'd50); set_lv(3, 8'd20); load[3] = 1'b1;
      tick();
      chk("pri_pre_cnt3", cnt(3), 20);
      clear[3] = 1'b1; enable[3] = 1'b1; set_lv(3, 8'd10);
      tick();
      chk("pri_clr_cnt3", cnt(3), 0);
      chk("pri_clr_tc3", tc[3], 0);
      clear[3] = 1'b0;
      tick();
      chk("pri_ld_cnt3", cnt(3), 10);
      chk("pri_ld_tc3", tc[3], 0);
      load[3] = 1'b0;
      // ch0 limit 0 up/wrap: tc every enabled cycle, count stays 0
      set_lim(0, 8'd0); enable[0] = 1'b1;
      tick();
      chk("lim0_cnt0", cnt(0), 0);
      chk("lim0_tc0", tc[0], 1);
      chk("lim0_cnt3", cnt(3), 11);
      cke = 1'b0;
      tick();
      chk("cke0_tc0", tc[0], 0);
      chk("cke0_cnt3", cnt(3), 11);
      chk("cke0_cycle", cycle, exp_cyc);
      cke = 1'b1;
      tick();
      chk("cke1_tc0", tc[0], 1);
      chk("cke1_cnt3", cnt(3), 12);
      chk("cke1_cycle", cycle, exp_cyc);
      enable = '0;

      // ch1 limit 0 up/sat: holds 0, no tc
      set_lv(1, 8'd0); load[1] = 1'b1;
      tick();
      load[1] = 1'b0; set_lim(1, 8'd0); enable[1] = 1'b1;
      tick();
      chk("lim0sat_cnt1", cnt(1), 0);
      chk("lim0sat_tc1", tc[1], 0);
      chk("lim0sat_ab1", at_bound[1], 1);
      enable[1] = 1'b0;

      // ch0 full-range roll-over and clamp
      set_lim(0, 8'd255); set_lv(0, 8'd254); load[0] = 1'b1;
      tick();
      chk("roll_load_cnt0", cnt(0), 254);
      load[0] = 1'b0; enable[0] = 1'b1;
      tick();
      chk("roll_cnt0_a", cnt(0), 255);
      chk("roll_tc0_a", tc[0], 0);
      tick();
      chk("roll_cnt0_b", cnt(0), 0);
      chk("roll_tc0_b", tc[0], 1);
      enable[0] = 1'b0; sat[0] = 1'b1; set_lim(0, 8'd100); set_lv(0, 8'd200); load[0] = 1'b1;
      tick();
      chk("clamp_load_cnt0", cnt(0), 200);
      load[0] = 1'b0; enable[0] = 1'b1;
      tick();
      chk("clamp_cnt0", cnt(0), 100);
      chk("clamp_tc0", tc[0], 1);
      tick();
      chk("clamp_hold_cnt0", cnt(0), 100);
      chk("clamp_hold_tc0", tc[0], 0);
      chk("clamp_ab0", at_bound[0], 1);
      enable = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
